// File: rtl/regfile_sb_if.sv
// Register-file bus: decode-side read/issue/flush and writeback-side write ports.
// The register file takes the slave modport; the pipeline drives the master modport.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();
    logic [NUM_RD*ADDR_W-1:0] iRAddr;
    logic [NUM_RD*DATA_W-1:0] oRData;
    logic [NUM_RD-1:0]        oRBusy;
    logic                     iWe0;
    logic [ADDR_W-1:0]        iWAddr0;
    logic [DATA_W-1:0]        iWData0;
    logic                     iWe1;
    logic [ADDR_W-1:0]        iWAddr1;
    logic [DATA_W-1:0]        iWData1;
    logic                     iIssue;
    logic [ADDR_W-1:0]        iIssueAddr;
    logic                     iFlush;
    logic [ADDR_W:0]          oBusyCnt;

    modport master (
        output iRAddr, iWe0, iWAddr0, iWData0, iWe1, iWAddr1, iWData1,
               iIssue, iIssueAddr, iFlush,
        input  oRData, oRBusy, oBusyCnt
    );

    modport slave (
        input  iRAddr, iWe0, iWAddr0, iWData0, iWe1, iWAddr1, iWData1,
               iIssue, iIssueAddr, iFlush,
        output oRData, oRBusy, oBusyCnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register pending scoreboard.
// NUM_RD combinational read ports with same-cycle forwarding from two write
// ports (port 1 wins), pending bits set at issue and cleared at writeback,
// and a registered count of pending registers.
// Optional build macro REGFILE_ZERO_REG_EN: register 0 is hardwired to zero,
// never forwarded, never pending.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  rf
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

    logic we0_eff, we1_eff, issue_eff;

    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    // Effective write/issue enables; with the zero register, address 0 is masked
    // here so that storage, forwarding and the scoreboard all ignore it.
    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        we0_eff   = rf.iWe0   && (rf.iWAddr0    != '0);
        we1_eff   = rf.iWe1   && (rf.iWAddr1    != '0);
        issue_eff = rf.iIssue && (rf.iIssueAddr != '0);
`else
        we0_eff   = rf.iWe0;
        we1_eff   = rf.iWe1;
        issue_eff = rf.iIssue;
`endif
    end

    // Storage next state: port 1 applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (we0_eff) mem_d[rf.iWAddr0] = rf.iWData0;
        if (we1_eff) mem_d[rf.iWAddr1] = rf.iWData1;
    end

    // Pending next state (flush > issue > writeback clear > hold) and its popcount.
    always_comb begin
        pend_d     = pend_q;
        busy_cnt_d = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (rf.iFlush) begin
                pend_d[r] = 1'b0;
            end else if (issue_eff && (rf.iIssueAddr == ADDR_W'(r))) begin
                pend_d[r] = 1'b1;
            end else if ((we0_eff && (rf.iWAddr0 == ADDR_W'(r))) ||
                         (we1_eff && (rf.iWAddr1 == ADDR_W'(r)))) begin
                pend_d[r] = 1'b0;
            end
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(pend_d[r]);
        end
    end

    // Read ports: forward write port 1, then port 0, else storage; a forwarded
    // value is final, so busy is suppressed for it.
    always_comb begin
        logic [ADDR_W-1:0] raddr;
        raddr   = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            raddr = rf.iRAddr[k*ADDR_W +: ADDR_W];
            if (we1_eff && (raddr == rf.iWAddr1)) begin
                rd_data[k*DATA_W +: DATA_W] = rf.iWData1;
                rd_busy[k]                  = 1'b0;
            end else if (we0_eff && (raddr == rf.iWAddr0)) begin
                rd_data[k*DATA_W +: DATA_W] = rf.iWData0;
                rd_busy[k]                  = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = mem_q[raddr];
                rd_busy[k]                  = pend_q[raddr];
            end
        end
    end

    assign rf.oRData   = rd_data;
    assign rf.oRBusy   = rd_busy;
    assign rf.oBusyCnt = busy_cnt_q;

    // State registers; synchronous reset overrides every same-cycle request.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            pend_q     <= pend_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expected values tagged with the
// cycle in which they must be visible; a negedge monitor pops and compares.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = read data, 1 = read busy, 2 = busy count
    typedef struct {
        int          tag;
        int          kind;
        int          port;
        logic [31:0] exp;
    } sb_t;

    sb_t sbq[$];

    function automatic void push(int tag, int kind, int port, logic [31:0] v);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        sbq.push_back(e);
    endfunction

    // Combinational expectations for the current cycle.
    function automatic void exp_rd(int k, logic [31:0] v);
        push(cyc, 0, k, v);
    endfunction
    function automatic void exp_busy(int k, logic b);
        push(cyc, 1, k, {31'b0, b});
    endfunction
    // Registered count, visible after the coming edge.
    function automatic void exp_cnt(int v);
        push(cyc + 1, 2, 0, 32'(v));
    endfunction

    // Monitor
    sb_t         me;
    logic [31:0] act;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
            me = sbq.pop_front();
            case (me.kind)
                0:       act = bus.oRData[me.port*DW +: DW];
                1:       act = {31'b0, bus.oRBusy[me.port]};
                default: act = 32'(bus.oBusyCnt);
            endcase
            tests++;
            if (me.tag != cyc || act !== me.exp) begin
                fails++;
                $display("FAIL %s port%0d cyc%0d (due %0d): got 0x%08h expected 0x%08h",
                         (me.kind == 0) ? "rdata" : (me.kind == 1) ? "rbusy" : "busycnt",
                         me.port, cyc, me.tag, act, me.exp);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.iRAddr     = '0;
        bus.iWe0       = 1'b0;
        bus.iWAddr0    = '0;
        bus.iWData0    = '0;
        bus.iWe1       = 1'b0;
        bus.iWAddr1    = '0;
        bus.iWData1    = '0;
        bus.iIssue     = 1'b0;
        bus.iIssueAddr = '0;
        bus.iFlush     = 1'b0;
    endtask

    task automatic set_ra(int k, int a);
        bus.iRAddr[k*AW +: AW] = AW'(a);
    endtask

    initial begin
        reset          = 1'b1;
        bus.iRAddr     = '0;
        bus.iWe0       = 1'b0;
        bus.iWAddr0    = '0;
        bus.iWData0    = '0;
        bus.iWe1       = 1'b0;
        bus.iWAddr1    = '0;
        bus.iWData1    = '0;
        bus.iIssue     = 1'b0;
        bus.iIssueAddr = '0;
        bus.iFlush     = 1'b0;
        repeat (2) @(posedge clk);

        // Post-reset: every address reads 0 and not busy on both ports.
        for (int a = 0; a < 32; a++) begin
            next_cycle();
            set_ra(0, a);
            set_ra(1, 31 - a);
            exp_rd(0, 32'h0); exp_rd(1, 32'h0);
            exp_busy(0, 1'b0); exp_busy(1, 1'b0);
            if (a == 0) exp_cnt(0);
        end

        // Write r5 with same-cycle forwarding, then read from storage.
        next_cycle();
        bus.iWe0 = 1'b1; bus.iWAddr0 = 5; bus.iWData0 = 32'hDEADBEEF;
        set_ra(0, 5);
        exp_rd(0, 32'hDEADBEEF); exp_busy(0, 1'b0);
        next_cycle();
        set_ra(0, 5);
        exp_rd(0, 32'hDEADBEEF);

        // Both ports write r7: port 1 wins forwarding and storage.
        next_cycle();
        bus.iWe0 = 1'b1; bus.iWAddr0 = 7; bus.iWData0 = 32'h1111;
        bus.iWe1 = 1'b1; bus.iWAddr1 = 7; bus.iWData1 = 32'h2222;
        set_ra(0, 5); set_ra(1, 7);
        exp_rd(0, 32'hDEADBEEF); exp_rd(1, 32'h2222);
        next_cycle();
        set_ra(1, 7);
        exp_rd(1, 32'h2222);

        // Issue r3, then r4.
        next_cycle();
        bus.iIssue = 1'b1; bus.iIssueAddr = 3;
        exp_cnt(1);
        next_cycle();
        bus.iIssue = 1'b1; bus.iIssueAddr = 4;
        set_ra(0, 3);
        exp_busy(0, 1'b1);
        exp_cnt(2);
        // Writeback r3 while re-issuing r3: stays pending.
        next_cycle();
        bus.iWe0 = 1'b1; bus.iWAddr0 = 3; bus.iWData0 = 32'h0303;
        bus.iIssue = 1'b1; bus.iIssueAddr = 3;
        set_ra(0, 4); set_ra(1, 3);
        exp_busy(0, 1'b1);
        exp_rd(1, 32'h0303); exp_busy(1, 1'b0);
        exp_cnt(2);
        next_cycle();
        set_ra(0, 3); set_ra(1, 4);
        exp_rd(0, 32'h0303);
        exp_busy(0, 1'b1); exp_busy(1, 1'b1);
        // Writeback r3 and r4 together.
        next_cycle();
        bus.iWe0 = 1'b1; bus.iWAddr0 = 3; bus.iWData0 = 32'h33;
        bus.iWe1 = 1'b1; bus.iWAddr1 = 4; bus.iWData1 = 32'h44;
        set_ra(0, 3); set_ra(1, 4);
        exp_rd(0, 32'h33); exp_rd(1, 32'h44);
        exp_busy(0, 1'b0); exp_busy(1, 1'b0);
        exp_cnt(0);
        next_cycle();
        set_ra(0, 3); set_ra(1, 4);
        exp_busy(0, 1'b0); exp_busy(1, 1'b0);
        exp_rd(0, 32'h33); exp_rd(1, 32'h44);

        // Pending r1, r2, then issue r9 with flush (plus a write that must land).
        next_cycle();
        bus.iIssue = 1'b1; bus.iIssueAddr = 1;
        exp_cnt(1);
        next_cycle();
        bus.iIssue = 1'b1; bus.iIssueAddr = 2;
        exp_cnt(2);
        next_cycle();
        bus.iIssue = 1'b1; bus.iIssueAddr = 9; bus.iFlush = 1'b1;
        bus.iWe0 = 1'b1; bus.iWAddr0 = 10; bus.iWData0 = 32'hA5A5;
        set_ra(0, 1); set_ra(1, 2);
        exp_busy(0, 1'b1); exp_busy(1, 1'b1);
        exp_cnt(0);
        next_cycle();
        set_ra(0, 9); set_ra(1, 10);
        exp_busy(0, 1'b0); exp_rd(1, 32'hA5A5);
        next_cycle();
        set_ra(0, 1); set_ra(1, 2);
        exp_busy(0, 1'b0); exp_busy(1, 1'b0);

        // Writeback to a non-pending register.
        next_cycle();
        bus.iWe1 = 1'b1; bus.iWAddr1 = 12; bus.iWData1 = 32'h1212;
        exp_cnt(0);
        next_cycle();
        set_ra(0, 12);
        exp_rd(0, 32'h1212); exp_busy(0, 1'b0);

        // Register 0: write 0xFFFF and issue r0 in the same cycle.
        next_cycle();
        bus.iWe0 = 1'b1; bus.iWAddr0 = 0; bus.iWData0 = 32'hFFFF;
        bus.iIssue = 1'b1; bus.iIssueAddr = 0;
        set_ra(0, 0);
`ifdef REGFILE_ZERO_REG_EN
        exp_rd(0, 32'h0); exp_busy(0, 1'b0);
        exp_cnt(0);
        next_cycle();
        set_ra(0, 0);
        exp_rd(0, 32'h0); exp_busy(0, 1'b0);
        next_cycle();
        bus.iWe0 = 1'b1; bus.iWAddr0 = 0; bus.iWData0 = 32'hFFFF;
        set_ra(0, 0);
        exp_rd(0, 32'h0);
        exp_cnt(0);
`else
        exp_rd(0, 32'hFFFF); exp_busy(0, 1'b0);
        exp_cnt(1);
        next_cycle();
        set_ra(0, 0);
        exp_rd(0, 32'hFFFF); exp_busy(0, 1'b1);
        next_cycle();
        bus.iWe0 = 1'b1; bus.iWAddr0 = 0; bus.iWData0 = 32'hFFFF;
        set_ra(0, 0);
        exp_rd(0, 32'hFFFF);
        exp_cnt(0);
`endif

        // Mid-operation reset: same-cycle write/issue ignored, state cleared.
        next_cycle();
        bus.iIssue = 1'b1; bus.iIssueAddr = 6;
        exp_cnt(1);
        next_cycle();
        reset = 1'b1;
        bus.iWe0 = 1'b1; bus.iWAddr0 = 8; bus.iWData0 = 32'h88;
        bus.iIssue = 1'b1; bus.iIssueAddr = 11;
        set_ra(0, 5); set_ra(1, 8);
        exp_rd(0, 32'hDEADBEEF); exp_rd(1, 32'h88);
        exp_busy(0, 1'b0);
        exp_cnt(0);
        next_cycle();
        set_ra(0, 5); set_ra(1, 8);
        exp_rd(0, 32'h0); exp_rd(1, 32'h0);
        next_cycle();
        set_ra(0, 6); set_ra(1, 11);
        exp_busy(0, 1'b0); exp_busy(1, 1'b0);
        exp_rd(0, 32'h0); exp_rd(1, 32'h0);

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
